// File: rtl/yarvi_fetch_queue.sv
// rtl/yarvi_fetch_queue.sv - instruction queue between yarvi_fe and yarvi_ex
//
// Circular buffer of DEPTH (pc, insn) pairs with valid/ready handshakes on
// both sides, a one-edge flush on restart, and an optional same-cycle
// bypass for an empty queue (enabled by defining YARVI_FQ_BYPASS_EN).
//
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   restart                flush all entries at the next edge
//   in_valid/in_ready      FE side handshake, with in_pc / in_insn
//   out_valid/out_ready    EX side handshake, with out_pc / out_insn (head)
//   count                  occupancy 0..DEPTH
module yarvi_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PCW   = 32,
  parameter int IW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     restart,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PCW-1:0]           in_pc,
  input  logic [IW-1:0]            in_insn,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PCW-1:0]           out_pc,
  output logic [IW-1:0]            out_insn,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0] rp_q, rp_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW:0]   count_q, count_d;

  // Storage is deliberately not reset; only pointers and occupancy are.
  logic [PCW-1:0] pc_mem   [DEPTH];
  logic [IW-1:0]  insn_mem [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_en;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL);
    // Both handshakes depend only on registered occupancy and reset, so a
    // pop in a full cycle cannot open a slot for a same-cycle push.
    in_ready = !full && !reset;
`ifdef YARVI_FQ_BYPASS_EN
    out_valid = (empty ? in_valid : 1'b1) && !reset;
    out_pc    = empty ? in_pc   : pc_mem[rp_q];
    out_insn  = empty ? in_insn : insn_mem[rp_q];
`else
    out_valid = !empty && !reset;
    out_pc    = pc_mem[rp_q];
    out_insn  = insn_mem[rp_q];
`endif
    push = in_valid && in_ready && !restart;
    pop  = out_valid && out_ready && !restart;
`ifdef YARVI_FQ_BYPASS_EN
    // An entry consumed straight from the input never touches storage.
    wr_en = push && !(empty && pop);
    rd_en = pop && !empty;
`else
    wr_en = push;
    rd_en = pop;
`endif
  end

  always_comb begin
    rp_d    = rd_en ? rp_q + 1'b1 : rp_q;
    wp_d    = wr_en ? wp_q + 1'b1 : wp_q;
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (reset || restart) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    rp_q    <= rp_d;
    wp_q    <= wp_d;
    count_q <= count_d;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      pc_mem[wp_q]   <= in_pc;
      insn_mem[wp_q] <= in_insn;
    end
  end

  assign count = count_q;

endmodule

// File: doc/yarvi_fetch_queue.md
# yarvi_fetch_queue

Parametrised instruction queue between `yarvi_fe` and `yarvi_ex`, replacing the direct single-entry `fe_valid`/`fe_pc`/`fe_insn` hand-off.
- Buffers up to DEPTH fetched (pc, insn) pairs with valid/ready handshakes on both sides, so fetch can run ahead of execute.
- Flushes all contents in one cycle on `restart`.
- Optional same-cycle bypass lets an empty queue hand an instruction straight to EX.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `PCW`, `` `VMSB+1 ``: pc width in bits.
- `IW`, 32: instruction width in bits.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `restart`  in  1  flush request from EX; same cycle as EX `restart`.
- `in_valid`  in  1  FE presents an entry.
- `in_ready`  out  1  queue accepts an entry this cycle.
- `in_pc`  in  PCW  pc of presented entry.
- `in_insn`  in  IW  instruction of presented entry.
- `out_valid`  out  1  head entry available to EX.
- `out_ready`  in  1  EX consumes head this cycle.
- `out_pc`  out  PCW  head pc.
- `out_insn`  out  IW  head instruction.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: circular buffer of DEPTH entries, read pointer `rp` and write pointer `wp`, each $clog2(DEPTH) bits, wrapping modulo DEPTH. `count` is a separate registered counter.
- Push: `in_valid & in_ready & !restart` writes the entry at `wp` and advances `wp`.
- Pop: `out_valid & out_ready & !restart` advances `rp`.
- Handshake outputs: `in_ready = (count != DEPTH) & !reset`; `out_valid = (count != 0) & !reset`, except in bypass mode (see Configuration).
- `out_pc`/`out_insn` show the entry at `rp`; their value is don't-care while `out_valid` = 0.
- Counter update:
  - push and pop in the same cycle: `count` unchanged.
  - push only: +1.
  - pop only: −1.
- Full (`count` = DEPTH): `in_ready` = 0. A pop in that cycle does not enable a same-cycle push; the freed slot is usable from the next cycle.
- Empty (`count` = 0): `out_valid` = 0 without bypass.
- Restart: next edge sets `rp` = `wp` = `count` = 0.
  - Any push or pop presented in the restart cycle is discarded.
  - The consumer must already mask `out_valid` with `!restart`.
- Reset: next edge sets `rp` = `wp` = `count` = 0. While `reset` is high, `in_ready` and `out_valid` are 0.
- Reset takes priority over restart; both clear the queue identically.
- Storage array is not reset; only pointers and counter are.
- No accepted entry is ever lost or duplicated except by restart or reset; order is strictly FIFO.

## Timing
- Latency without bypass: entry pushed at edge N is at the head, with `out_valid` = 1, in cycle N+1 when the queue was empty.
- Throughput: one push and one pop per cycle sustained for any occupancy 1..DEPTH−1.
- `in_ready`, `out_valid` and `count` are functions of registered state and `reset` only; no combinational path from `out_ready` to `in_ready`.
- Flush takes one edge: the cycle after `restart`, `count` = 0, `out_valid` = 0 and `in_ready` = 1.
- A push in the cycle after restart (new `restart_pc` stream) is accepted normally.

## Configuration
- `YARVI_FQ_BYPASS_EN` defined:
  - When `count` = 0, `out_valid = in_valid & !reset`, and `out_pc`/`out_insn` = `in_pc`/`in_insn` combinationally.
  - If `out_ready` is also 1 in that cycle, the entry is consumed directly: not written, `wp` and `count` unchanged.
  - If `out_ready` = 0, the entry is written normally.
  - Adds a combinational `in_*` → `out_*` path; zero-cycle latency when empty.
- `YARVI_FQ_BYPASS_EN` undefined: no combinational input-to-output path; minimum latency one cycle, as in Timing.

## Test plan
- Reset, then DEPTH=4, bypass off:
  - push pc 0x100, 0x104, 0x108, 0x10C with `out_ready` = 0 → `count` 1,2,3,4, `in_ready` = 0 after the fourth.
  - then `out_ready` = 1 → out_pc 0x100..0x10C in order over 4 cycles, `count` → 0.
- Wrap-around: steady push+pop for 10 cycles, pc 0x200+4k, with one entry resident → `count` stays 1; out_pc lags in_pc by exactly one cycle with no gaps; pointers wrap twice without error.
- Full plus pop: at `count` = 4, assert `in_valid` and `out_ready` together → head popped, push refused, `count` = 3; the next cycle's push is accepted, `count` = 4.
- Restart: with `count` = 3, assert `restart` together with `in_valid` and `out_ready` → next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1; pushed entry absent; a subsequent push of 0x400 emerges as the next out_pc.
- Reset mid-operation: `count` = 2, assert `reset` one cycle → `in_ready`/`out_valid` = 0 during reset, `count` = 0 after; no stale entry appears.
- With `YARVI_FQ_BYPASS_EN`, empty queue, push 0x500 with `out_ready` = 1 → `out_valid` = 1 and out_pc = 0x500 in the same cycle; `count` stays 0.
